uart_frame_parser: RTL and testbench

// - Sits directly downstream of the UART receiver; consumes its one-cycle byte strobe and byte.
// - Frame format: SYNC, LEN, LEN payload bytes, CHK.
// - Buffers the payload and checks length and checksum; aborts on inter-byte timeout.
// - Releases a good payload on a valid/ready byte stream; bad frames are discarded and flagged.

---
 rtl/uart_frame_parser.sv | 185 ++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: turns the UART RX byte strobe into SYNC/LEN/payload/CHK
// frames, buffers the payload, validates length and checksum, and drains a
// good payload on a registered valid/ready byte stream.
module uart_frame_parser #(
    parameter int         CLK_FREQ_HZ  = 50_000_000,
    parameter logic [7:0] SYNC_BYTE    = 8'hAA,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 50_000
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic [7:0] o_Data,
    output logic       o_Valid,
    input  logic       i_Ready,
    output logic       o_Last,
    output logic       o_Frame_OK,
    output logic       o_Err_Chk,
    output logic       o_Err_Len,
    output logic       o_Err_Timeout,
    output logic       o_Drop,
    output logic       o_Busy
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);

    // Clock frequency is informational only; it sets no timing here.
    if (CLK_FREQ_HZ > 0) begin : g_clk_info
    end

    typedef enum logic [2:0] {S_SYNC, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   len_q, len_d, wr_q, wr_d, rd_q, rd_d, rd_nxt;
    logic [7:0]      sum_q, sum_d, data_q, data_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            valid_q, valid_d, last_q, last_d;
    logic            ok_q, ok_d, err_chk_q, err_chk_d, err_len_q, err_len_d;
    logic            err_to_q, err_to_d, drop_q, drop_d, busy_q, busy_d;
    logic            wr_en, in_frame, timeout;
    logic [7:0]      mem_q [MAX_LEN];

    // Next-state logic: frame FSM, checksum, timeout and drain pointer.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        rd_nxt    = rd_q + LW'(1);
        sum_d     = sum_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        ok_d      = 1'b0;
        err_chk_d = 1'b0;
        err_len_d = 1'b0;
        err_to_d  = 1'b0;
        drop_d    = 1'b0;
        wr_en     = 1'b0;
        in_frame  = state_q inside {S_LEN, S_PAYLOAD, S_CHK};
        // A byte in the expiry cycle clears the counter, so it wins.
        timeout   = in_frame && !i_Rx_DV && (cnt_q == TO_LAST);
        cnt_d     = (in_frame && !i_Rx_DV && !timeout) ? cnt_q + TW'(1) : '0;

        case (state_q)
            S_SYNC: begin
                if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) state_d = S_LEN;
            end
            S_LEN: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte != 8'd0 && i_Rx_Byte <= 8'(MAX_LEN)) begin
                        len_d   = i_Rx_Byte[LW-1:0];
                        sum_d   = i_Rx_Byte;
                        wr_d    = '0;
                        state_d = S_PAYLOAD;
                    end else begin
                        err_len_d = 1'b1;
                        state_d   = S_SYNC;
                    end
                end
            end
            S_PAYLOAD: begin
                if (i_Rx_DV) begin
                    wr_en = 1'b1;
                    wr_d  = wr_q + LW'(1);
                    sum_d = sum_q + i_Rx_Byte;
                    if (wr_q + LW'(1) == len_q) state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (i_Rx_DV) begin
                    if (8'(sum_q + i_Rx_Byte) == 8'd0) begin
                        ok_d    = 1'b1;
                        rd_d    = '0;
                        state_d = S_DRAIN;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = S_SYNC;
                    end
                end
            end
            S_DRAIN: begin
                drop_d = i_Rx_DV;
                if (!valid_q) begin
                    // First cycle in drain: present byte 0.
                    valid_d = 1'b1;
                    data_d  = mem_q[rd_q[AW-1:0]];
                    last_d  = (rd_q == len_q - LW'(1));
                end else if (i_Ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = S_SYNC;
                    end else begin
                        rd_d   = rd_nxt;
                        data_d = mem_q[rd_nxt[AW-1:0]];
                        last_d = (rd_nxt == len_q - LW'(1));
                    end
                end
            end
            default: state_d = S_SYNC;
        endcase

        if (timeout) begin
            err_to_d = 1'b1;
            state_d  = S_SYNC;
        end
        busy_d = (state_d != S_SYNC);
    end

    // Control and output registers; synchronous reset overrides everything.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= S_SYNC;
            len_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            ok_q      <= 1'b0;
            err_chk_q <= 1'b0;
            err_len_q <= 1'b0;
            err_to_q  <= 1'b0;
            drop_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            ok_q      <= ok_d;
            err_chk_q <= err_chk_d;
            err_len_q <= err_len_d;
            err_to_q  <= err_to_d;
            drop_q    <= drop_d;
            busy_q    <= busy_d;
        end
    end

    // Payload buffer; contents need no reset since rd never passes wr.
    always_ff @(posedge i_Clock) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= i_Rx_Byte;
    end

    assign o_Data        = data_q;
    assign o_Valid       = valid_q;
    assign o_Last        = last_q;
    assign o_Frame_OK    = ok_q;
    assign o_Err_Chk     = err_chk_q;
    assign o_Err_Len     = err_len_q;
    assign o_Err_Timeout = err_to_q;
    assign o_Drop        = drop_q;
    assign o_Busy        = busy_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: expected payload bytes are queued
// as frames are sent and popped on every output handshake.
module tb_uart_frame_parser;
    localparam int MAX_LEN = 16;
    localparam int TO      = 32;

    logic       clk = 1'b0, rst = 1'b1, dv = 1'b0, ready = 1'b1;
    logic [7:0] rxb = 8'h00;
    logic [7:0] o_Data;
    logic       o_Valid, o_Last, o_Frame_OK, o_Err_Chk, o_Err_Len;
    logic       o_Err_Timeout, o_Drop, o_Busy;

    uart_frame_parser #(.SYNC_BYTE(8'hAA), .MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(TO)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(dv), .i_Rx_Byte(rxb),
        .o_Data(o_Data), .o_Valid(o_Valid), .i_Ready(ready), .o_Last(o_Last),
        .o_Frame_OK(o_Frame_OK), .o_Err_Chk(o_Err_Chk), .o_Err_Len(o_Err_Len),
        .o_Err_Timeout(o_Err_Timeout), .o_Drop(o_Drop), .o_Busy(o_Busy));

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    logic [8:0] sb [$];
    int c_ok = 0, c_chk = 0, c_len = 0, c_to = 0, c_drop = 0;
    int b_ok = 0, b_chk = 0, b_len = 0, b_to = 0, b_drop = 0;
    int cyc = 0, ok_cyc = 0;
    logic       prev_stall = 0, prev_vld = 0, prev_hs_mid = 0;
    logic [8:0] prev_word = '0, e;

    // Output monitor: pulse counting, handshake scoreboard, stall/bubble checks.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 0; prev_vld = 0; prev_hs_mid = 0;
        end else begin
            if (o_Frame_OK) begin c_ok++; ok_cyc = cyc; end
            if (o_Err_Chk) c_chk++;
            if (o_Err_Len) c_len++;
            if (o_Err_Timeout) c_to++;
            if (o_Drop) c_drop++;
            if (o_Frame_OK | o_Err_Chk | o_Err_Len | o_Err_Timeout)
                chk("pulse_excl", 32'(o_Frame_OK) + 32'(o_Err_Chk) + 32'(o_Err_Len)
                    + 32'(o_Err_Timeout), 1);
            if (o_Valid && !prev_vld) chk("first_vld_lat", cyc - ok_cyc, 1);
            if (prev_stall) chk("stall_hold", {o_Valid, o_Last, o_Data}, {1'b1, prev_word});
            if (prev_hs_mid) chk("no_bubble", o_Valid, 1);
            if (o_Valid && ready) begin
                if (sb.size() == 0) chk("unexp_vld", o_Valid, 0);
                else begin
                    e = sb.pop_front();
                    chk("out_data", o_Data, e[7:0]);
                    chk("out_last", o_Last, e[8]);
                end
            end
            prev_stall  = o_Valid && !ready;
            prev_word   = {o_Last, o_Data};
            prev_vld    = o_Valid;
            prev_hs_mid = o_Valid && ready && !o_Last;
        end
    end

    // One byte strobe after 'idle' extra clock edges; starts just after an edge.
    task automatic strobe(input int idle, input logic [7:0] b);
        repeat (idle) @(posedge clk);
        #1; dv = 1'b1; rxb = b;
        @(posedge clk); #1; dv = 1'b0;
    endtask

    task automatic send(input logic [7:0] q [$]);
        foreach (q[i]) strobe(1, q[i]);
    endtask

    // Good frame: checksum makes LEN + payload + CHK sum to zero mod 256.
    task automatic good(input logic [7:0] pl [$]);
        logic [7:0] f [$];
        logic [7:0] s;
        s = 8'(pl.size());
        f.push_back(8'hAA);
        f.push_back(8'(pl.size()));
        foreach (pl[i]) begin
            s = s + pl[i];
            f.push_back(pl[i]);
            sb.push_back({(i == pl.size() - 1), pl[i]});
        end
        f.push_back(8'(-s));
        send(f);
    endtask

    task automatic pulses(input string tag, input int ok, input int ce, input int le,
                          input int te, input int dr);
        chk({tag, "_ok"}, c_ok - b_ok, ok);
        chk({tag, "_errchk"}, c_chk - b_chk, ce);
        chk({tag, "_errlen"}, c_len - b_len, le);
        chk({tag, "_errto"}, c_to - b_to, te);
        chk({tag, "_drop"}, c_drop - b_drop, dr);
        b_ok = c_ok; b_chk = c_chk; b_len = c_len; b_to = c_to; b_drop = c_drop;
    endtask

    task automatic settle(input string tag);
        int k = 0;
        repeat (3) @(posedge clk);
        while ((sb.size() != 0 || o_Busy) && k < 300) begin @(posedge clk); k++; end
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_idle"}, {o_Busy, sb.size() != 0}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] pl [$];
        int k;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {o_Data, o_Valid, o_Last, o_Frame_OK, o_Err_Chk, o_Err_Len,
            o_Err_Timeout, o_Drop, o_Busy}, 0);
        rst = 1'b0;

        // Good 3-byte frame.
        good('{8'h11, 8'h22, 8'h33});
        settle("good3"); pulses("good3", 1, 0, 0, 0, 0);

        // Same payload with a wrong checksum byte.
        send('{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'hB7});
        settle("badB7"); pulses("badB7", 0, 1, 0, 0, 0);

        // Bad checksum, then a good 1-byte frame.
        send('{8'hAA, 8'h02, 8'h01, 8'h02, 8'h00});
        settle("bad"); pulses("bad", 0, 1, 0, 0, 0);
        good('{8'h05});
        settle("one"); pulses("one", 1, 0, 0, 0, 0);

        // Stray bytes ignored, LEN 0 and LEN 17 rejected.
        send('{8'h55, 8'h12, 8'hAA, 8'h00});
        send('{8'hAA, 8'h11});
        settle("len"); pulses("len", 0, 0, 2, 0, 0);

        // Full-size frame with SYNC values inside as data.
        pl.delete();
        for (int i = 0; i < MAX_LEN; i++) pl.push_back((i % 5 == 0) ? 8'hAA : 8'($urandom));
        good(pl);
        settle("max"); pulses("max", 1, 0, 0, 0, 0);

        // Backpressure with ready 1,0,0,... and a byte strobed mid-drain.
        pl.delete();
        for (int i = 0; i < 4; i++) pl.push_back(8'($urandom));
        good(pl);
        for (k = 0; k < 60; k++) begin
            ready = (k % 3 == 0);
            dv = (k == 4);
            rxb = 8'hAA;
            @(posedge clk); #1;
        end
        dv = 1'b0; ready = 1'b1;
        settle("bp"); pulses("bp", 1, 0, 0, 0, 1);

        // Timeout after exactly TO idle clocks.
        send('{8'hAA, 8'h03, 8'h11});
        repeat (TO - 1) @(posedge clk);
        #1; chk("to_not_early", o_Err_Timeout, 0);
        @(posedge clk); #1;
        chk("to_pulse", o_Err_Timeout, 1);
        chk("to_busy", o_Busy, 0);
        settle("to"); pulses("to", 0, 0, 0, 1, 0);

        // Byte on the expiry cycle keeps the frame alive.
        sb.push_back({1'b0, 8'h11}); sb.push_back({1'b0, 8'h22}); sb.push_back({1'b1, 8'h33});
        send('{8'hAA, 8'h03, 8'h11});
        strobe(TO - 1, 8'h22);
        send('{8'h33, 8'h97});
        settle("edge"); pulses("edge", 1, 0, 0, 0, 0);

        // Reset during drain, then a clean frame.
        ready = 1'b0;
        good('{8'h31, 8'h32, 8'h33});
        k = 0;
        while (!o_Valid && k < 50) begin @(posedge clk); #1; k++; end
        chk("rst_wait_vld", o_Valid, 1);
        ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        ready = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_vld", o_Valid, 0);
        chk("rst_busy", o_Busy, 0);
        chk("rst_left", sb.size(), 1);
        sb.delete();
        ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("rst_quiet", o_Valid, 0);
        b_ok = c_ok; b_chk = c_chk; b_len = c_len; b_to = c_to; b_drop = c_drop;
        good('{8'h41, 8'h42});
        settle("post"); pulses("post", 1, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
